// File: rtl/div_seq.sv
// div_seq: multi-cycle radix-2 restoring divider for MIPS DIV/DIVU (quotient to LO, remainder to HI).
// Optional macro DIV_SEQ_ZERO_FAST_EN: a zero divisor skips the iteration and completes in 2 cycles.
module div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sign,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] oQ,
  output logic [WIDTH-1:0] oR
);

  localparam int unsigned   CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_dvd;
  logic [WIDTH-1:0] r_dvs;
  logic [CW-1:0]    r_cnt;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_b_zero;
  logic             w_a_neg;
  logic             w_b_neg;
  logic             w_zero_fast;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH:0]   w_shift;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic             w_load;
  logic             w_step;
  logic             w_fin;

  // A zero divisor keeps the dividend raw so the iteration leaves rem = iA and q = all ones.
  assign w_b_zero = (iB == '0);
  assign w_a_neg  = sign & iA[WIDTH-1] & ~w_b_zero;
  assign w_b_neg  = sign & iB[WIDTH-1];
  assign w_a_mag  = w_a_neg ? -iA : iA;
  assign w_b_mag  = w_b_neg ? -iB : iB;

`ifdef DIV_SEQ_ZERO_FAST_EN
  assign w_zero_fast = w_b_zero;
`else
  assign w_zero_fast = 1'b0;
`endif

  // Top bit of the shifted partial remainder lives in bit WIDTH; diff[WIDTH] set means borrow.
  assign w_shift  = {r_rem, r_dvd[WIDTH-1]};
  assign w_diff   = w_shift - {1'b0, r_dvs};
  assign w_borrow = w_diff[WIDTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = w_zero_fast ? S_SIGN : S_CALC;
      S_CALC:  if (r_cnt == LAST) w_state_nxt = S_SIGN;
      S_SIGN:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_load = 1'b0;
    w_step = 1'b0;
    w_fin  = 1'b0;
    case (r_state)
      S_IDLE:  w_load = start;
      S_CALC:  w_step = 1'b1;
      S_SIGN:  w_fin  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rem   <= '0;
      r_dvd   <= '0;
      r_dvs   <= '0;
      r_cnt   <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      oQ      <= '0;
      oR      <= '0;
    end else begin
      done <= w_fin;
      if (w_load) begin
        r_dvs   <= w_b_mag;
        r_cnt   <= '0;
        r_neg_q <= sign & (iA[WIDTH-1] ^ iB[WIDTH-1]) & ~w_b_zero;
        r_neg_r <= w_a_neg;
        busy    <= 1'b1;
        if (w_zero_fast) begin
          r_dvd <= '1;
          r_rem <= iA;
        end else begin
          r_dvd <= w_a_mag;
          r_rem <= '0;
        end
      end
      if (w_step) begin
        r_rem <= w_borrow ? w_shift[WIDTH-1:0] : w_diff[WIDTH-1:0];
        r_dvd <= {r_dvd[WIDTH-2:0], ~w_borrow};
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_fin) begin
        busy <= 1'b0;
        oQ   <= r_neg_q ? -r_dvd : r_dvd;
        oR   <= r_neg_r ? -r_rem : r_rem;
      end
    end
  end

endmodule
